// File: rtl/music_seq.sv
// music_seq: plays a score held in an external synchronous ROM.
// Each entry is a note code plus a length in beat units. The sequencer
// fetches an entry, restarts an external beat counter with the scaled
// length, plays the note until the counter finishes, then moves on.
// Code 8'hFF marks the end of the score. At the end marker the sequencer
// either wraps to address 0 (loop) or stops in DONE.
`timescale 1ns/1ps
module music_seq #(
  parameter int          ADDR_W    = 8,
  parameter logic [27:0] BEAT_UNIT = 28'd3_125_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [30:0]       mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  input  logic              beat_finish,
  output logic              beat_rst_n,
  output logic              beat_en,
  output logic [27:0]       beat_cnt_parameter,
  output logic [7:0]        note_code,
  output logic              note_valid,
  output logic              song_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ARM   = 3'd3,
    PLAY  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] END_MARKER = 8'hFF;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          note_q, note_d;
  logic [27:0]         param_q, param_d;
  logic                guard_q, guard_d;
  logic                beat_rst_n_q;
  logic                note_valid_q;
  logic                song_done_q;

  // Score entry decode, valid while in LOAD.
  logic                is_end;
  logic [3:0]          len_units;
  logic [27:0]         len_product;
  logic                loop_en;

  // Only the loop bit of the mode word is meaningful.
  logic                unused_mode_bits;
  assign unused_mode_bits = ^{mode[30:5], mode[3:0]};
  assign loop_en          = mode[4];

  // Decode the ROM entry; a zero length still plays one unit. Within the
  // legal BEAT_UNIT range 15*BEAT_UNIT fits in 28 bits, so the natural
  // 28-bit truncation of the product never loses information.
  always_comb begin
    is_end      = (rom_data[11:4] == END_MARKER);
    len_units   = (rom_data[3:0] == 4'd0) ? 4'd1 : rom_data[3:0];
    len_product = {24'd0, len_units} * BEAT_UNIT;
  end

  // Next-state, address and note-register logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    param_d = param_q;
    guard_d = guard_q;

    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (en) begin
          state_d = FETCH;
        end
      end

      // One cycle so the registered address reaches the ROM output.
      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        if (is_end) begin
          if (loop_en) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end else begin
          note_d  = rom_data[11:4];
          param_d = len_product;
          state_d = ARM;
        end
      end

      // Beat counter is being restarted; the next PLAY cycle is a guard
      // cycle because beat_finish may still reflect the previous note.
      ARM: begin
        guard_d = 1'b1;
        state_d = PLAY;
      end

      PLAY: begin
        guard_d = 1'b0;
        if (en && !guard_q && beat_finish) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end

      DONE: begin
        if (!en) begin
          addr_d  = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address and note registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      note_q  <= 8'd0;
      param_q <= 28'd0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      param_q <= param_d;
      guard_q <= guard_d;
    end
  end

  // Flopped status outputs, decoded from the next state so they line up
  // with the state they describe and never glitch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_rst_n_q <= 1'b0;
      note_valid_q <= 1'b0;
      song_done_q  <= 1'b0;
    end else begin
      beat_rst_n_q <= (state_d != ARM);
      note_valid_q <= (state_d == ARM) || (state_d == PLAY);
      song_done_q  <= (state_d == DONE);
    end
  end

  assign rom_addr           = addr_q;
  assign note_code          = note_q;
  assign beat_cnt_parameter = param_q;
  assign beat_rst_n         = beat_rst_n_q;
  assign note_valid         = note_valid_q;
  assign song_done          = song_done_q;
  // Pausing must stop the beat counter in the same cycle en drops.
  assign beat_en            = en && (state_q == PLAY);

endmodule

// File: tb/tb_music_seq.sv
// tb_music_seq: scoreboard bench for music_seq with a ROM and beat counter model.
`timescale 1ns/1ps
module tb_music_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [30:0] mode = 31'd0;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data = 12'd0;
  logic        beat_finish;
  logic        beat_rst_n;
  logic        beat_en;
  logic [27:0] beat_cnt_parameter;
  logic [7:0]  note_code;
  logic        note_valid;
  logic        song_done;

  logic        force_finish = 1'b0;
  logic [27:0] bcnt = 28'd0;
  logic [11:0] rom [256];

  int n_tests = 0;
  int n_fail = 0;
  int beat_en_total = 0;

  typedef struct packed {
    logic [7:0]  note;
    logic [27:0] param;
  } exp_t;
  exp_t exp_q[$];

  music_seq #(.ADDR_W(8), .BEAT_UNIT(28'd4)) dut (
    .clk(clk),
    .rstn(rstn),
    .en(en),
    .mode(mode),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .beat_finish(beat_finish),
    .beat_rst_n(beat_rst_n),
    .beat_en(beat_en),
    .beat_cnt_parameter(beat_cnt_parameter),
    .note_code(note_code),
    .note_valid(note_valid),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Synchronous score ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Beat counter: cleared while beat_rst_n low, counts enabled cycles,
  // finishes on the beat_cnt_parameter-th enabled cycle.
  always @(posedge clk) begin
    if (!beat_rst_n) bcnt <= 28'd0;
    else if (beat_en) bcnt <= bcnt + 28'd1;
  end
  assign beat_finish = force_finish | (beat_en && (bcnt == beat_cnt_parameter - 28'd1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'hFF0;
  endtask

  task automatic push_exp(input logic [7:0] note, input logic [27:0] param);
    exp_t e;
    e.note  = note;
    e.param = param;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 2000 && !song_done; i++) tick();
    check_eq(tag, 32'(song_done), 32'd1);
  endtask

  task automatic wait_sb_empty(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_playing(input string tag, input logic [7:0] addr);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (note_valid && beat_rst_n && rom_addr == addr) break;
      tick();
    end
    check_eq(tag, 32'(i < 2000), 32'd1);
  endtask

  // Leave DONE by dropping en and confirm the return to IDLE.
  task automatic finish_song(input string tag);
    check_eq({tag, "_beat_en_done"}, 32'(beat_en), 32'd0);
    check_eq({tag, "_nv_done"}, 32'(note_valid), 32'd0);
    check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    en = 1'b0;
    tick(2);
    check_eq({tag, "_done_clr"}, 32'(song_done), 32'd0);
    check_eq({tag, "_addr_idle"}, 32'(rom_addr), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_addr"}, 32'(rom_addr), 32'd0);
    check_eq({tag, "_beat_rst_n"}, 32'(beat_rst_n), 32'd0);
    check_eq({tag, "_param"}, 32'(beat_cnt_parameter), 32'd0);
    check_eq({tag, "_note"}, 32'(note_code), 32'd0);
    check_eq({tag, "_nv"}, 32'(note_valid), 32'd0);
    check_eq({tag, "_done"}, 32'(song_done), 32'd0);
    check_eq({tag, "_beat_en"}, 32'(beat_en), 32'd0);
  endtask

  // Scoreboard monitor: each ARM pulse (beat_rst_n low) pops one entry.
  initial begin
    exp_t e;
    int low_cnt;
    low_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        low_cnt = 0;
      end else begin
        if (beat_en) beat_en_total++;
        if (!beat_rst_n) begin
          if (low_cnt == 0) begin
            if (exp_q.size() == 0) begin
              check_eq("sb_unexpected_note", 32'(note_code), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              $display("[TB] note %02h param %0d (exp %02h %0d)",
                       note_code, beat_cnt_parameter, e.note, e.param);
              check_eq("sb_note", 32'(note_code), 32'(e.note));
              check_eq("sb_param", 32'(beat_cnt_parameter), 32'(e.param));
              check_eq("sb_nv_arm", 32'(note_valid), 32'd1);
              check_eq("sb_beat_en_arm", 32'(beat_en), 32'd0);
            end
          end
          low_cnt++;
        end else begin
          if (low_cnt != 0) check_eq("arm_pulse_width", 32'(low_cnt), 32'd1);
          low_cnt = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;

    // Reset values and release.
    clear_rom();
    tick(2);
    check_reset_values("reset");
    @(negedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_release_beat_rst_n", 32'(beat_rst_n), 32'd1);
    tick(2);

    // Basic play, no loop.
    rom[0] = {8'h12, 4'd2};
    rom[1] = 12'hFF0;
    mode = 31'd0;
    push_exp(8'h12, 28'd8);
    en = 1'b1;
    wait_done("basic_done");
    check_eq("basic_note_hold", 32'(note_code), 32'h12);
    check_eq("basic_param_hold", 32'(beat_cnt_parameter), 32'd8);
    finish_song("basic");

    // Loop: the note replays, then loop is turned off to finish.
    mode = 31'h10;
    push_exp(8'h12, 28'd8);
    push_exp(8'h12, 28'd8);
    en = 1'b1;
    wait_sb_empty("loop_replay");
    check_eq("loop_not_done", 32'(song_done), 32'd0);
    mode = 31'd0;
    wait_done("loop_done");
    finish_song("loop");

    // Length zero plays one unit.
    rom[0] = {8'h05, 4'd0};
    push_exp(8'h05, 28'd4);
    en = 1'b1;
    wait_done("len0_done");
    finish_song("len0");

    // Pause for 10 cycles mid-note.
    rom[0] = {8'h33, 4'd3};
    push_exp(8'h33, 28'd12);
    start = beat_en_total;
    en = 1'b1;
    wait_playing("pause_reach_play", 8'd0);
    tick(3);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("pause_beat_en", 32'(beat_en), 32'd0);
      check_eq("pause_addr", 32'(rom_addr), 32'd0);
      check_eq("pause_note", 32'(note_code), 32'h33);
      check_eq("pause_nv", 32'(note_valid), 32'd1);
    end
    en = 1'b1;
    wait_done("pause_done");
    check_eq("pause_beat_cycles", 32'(beat_en_total - start), 32'd12);
    finish_song("pause");

    // beat_finish tied high: two PLAY cycles per entry, none skipped.
    clear_rom();
    rom[0] = {8'hA1, 4'd1};
    rom[1] = {8'hA2, 4'd2};
    rom[2] = {8'hA3, 4'd3};
    push_exp(8'hA1, 28'd4);
    push_exp(8'hA2, 28'd8);
    push_exp(8'hA3, 28'd12);
    force_finish = 1'b1;
    start = beat_en_total;
    en = 1'b1;
    wait_done("guard_done");
    check_eq("guard_beat_cycles", 32'(beat_en_total - start), 32'd6);
    force_finish = 1'b0;
    finish_song("guard");

    // Reset while playing address 3, then restart from address 0.
    clear_rom();
    for (int i = 0; i < 4; i++) begin
      rom[i] = {8'(8'h40 + i), 4'd1};
      push_exp(8'(8'h40 + i), 28'd4);
    end
    en = 1'b1;
    wait_playing("midrst_reach_addr3", 8'd3);
    rstn = 1'b0;
    #1;
    check_reset_values("midrst");
    check_eq("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick(2);
    for (int i = 0; i < 4; i++) push_exp(8'(8'h40 + i), 28'd4);
    @(negedge clk);
    #1 rstn = 1'b1;
    wait_done("midrst_done");
    finish_song("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
